// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: ALU operation and forward-select encodings,
// plus the operand forwarding mux used by the execute stage.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // The unused 11 encoding falls back to the register-file value.
  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] rf_val,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] mem_val
  );
    logic [XLEN-1:0] val;
    case (sel)
      FWD_WB:  val = wb_val;
      FWD_MEM: val = mem_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit RV32I ALU; carry and overflow are discarded and
// zero is produced for every operation.
module alu
  import riscv_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [2:0]  alu_control,
  output logic [31:0] alu_result,
  output logic        zero
);

  logic [4:0] shamt;
  logic       lt;

  assign shamt = src_b[4:0];
  assign lt    = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (alu_op_t'(alu_control))
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {31'b0, lt};
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRA: alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == 32'b0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the E/M pipeline register. Define FORWARDING_EN to enable the forward muxes.
module execute_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_e,
  input  logic [31:0] pc_plus4_e,
  input  logic        jump_e,
  input  logic        branch_e,
  input  logic        mem_write_e,
  input  logic        alu_src_e,
  input  logic        reg_write_e,
  input  logic [1:0]  result_src_e,
  input  logic [2:0]  alu_control_e,
  input  logic [31:0] rd1_e,
  input  logic [31:0] rd2_e,
  input  logic [4:0]  rd_e,
  input  logic [31:0] imm_ext_e,
  input  logic [1:0]  forward_a_e,
  input  logic [1:0]  forward_b_e,
  input  logic [31:0] result_w,
  output logic        pc_src_e,
  output logic [31:0] pc_target_e,
  output logic        reg_write_m,
  output logic        mem_write_m,
  output logic [1:0]  result_src_m,
  output logic [31:0] alu_result_m,
  output logic [31:0] write_data_m,
  output logic [31:0] pc_plus4_m,
  output logic [4:0]  rd_m
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;

`ifdef FORWARDING_EN
  // M-stage forwarding reads the registered result, so no combinational loop.
  assign src_a = fwd_mux(forward_a_e, rd1_e, result_w, alu_result_m);
  assign fwd_b = fwd_mux(forward_b_e, rd2_e, result_w, alu_result_m);
`else
  logic unused_fwd;
  assign unused_fwd = ^{forward_a_e, forward_b_e, result_w};
  assign src_a = rd1_e;
  assign fwd_b = rd2_e;
`endif

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;

  alu u_alu (
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control_e),
    .alu_result  (alu_result),
    .zero        (zero)
  );

  assign pc_src_e    = (branch_e & zero) | jump_e;
  assign pc_target_e = pc_e + imm_ext_e;

  // Store data is always the forwarded rs2 value, never the immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 2'b0;
      alu_result_m <= 32'b0;
      write_data_m <= 32'b0;
      pc_plus4_m   <= 32'b0;
      rd_m         <= 5'b0;
    end else begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      alu_result_m <= alu_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural model;
// follows FORWARDING_EN the same way the design does.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, result_w;
  logic        jump_e, branch_e, mem_write_e, alu_src_e, reg_write_e;
  logic [1:0]  result_src_e, forward_a_e, forward_b_e;
  logic [2:0]  alu_control_e;
  logic [4:0]  rd_e;
  logic        pc_src_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_m_alu = 32'b0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .jump_e(jump_e), .branch_e(branch_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
    .alu_control_e(alu_control_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .rd_e(rd_e),
    .imm_ext_e(imm_ext_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .result_w(result_w), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
`ifdef FORWARDING_EN
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
`endif
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh = int'(b[4:0]);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return a << sh;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  task automatic set_txn(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] imm,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] rw,
                         input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                         input logic as, input logic br, input logic jp);
    pc_e = pc; pc_plus4_e = pc4; imm_ext_e = imm; rd1_e = r1; rd2_e = r2; result_w = rw;
    alu_control_e = op; forward_a_e = fa; forward_b_e = fb;
    alu_src_e = as; branch_e = br; jump_e = jp;
    reg_write_e = 1'($urandom); mem_write_e = 1'($urandom);
    result_src_e = 2'($urandom); rd_e = 5'($urandom);
  endtask

  // Called with clk low; checks combinational outputs, then the E/M load.
  task automatic run_txn(input string tag);
    logic [31:0] a, fb, b, res, tgt;
    logic        psrc;
    logic [8:0]  ctl;
    a    = pick(forward_a_e, rd1_e, result_w, model_m_alu);
    fb   = pick(forward_b_e, rd2_e, result_w, model_m_alu);
    b    = alu_src_e ? imm_ext_e : fb;
    res  = alu_ref(int'(alu_control_e), a, b);
    psrc = jump_e || (branch_e && res == 0);
    tgt  = 32'(64'(pc_e) + 64'(imm_ext_e));
    ctl  = {reg_write_e, mem_write_e, result_src_e, rd_e};
    #1;
    check({tag, ".pc_src"}, {31'b0, pc_src_e}, {31'b0, psrc});
    check({tag, ".target"}, pc_target_e, tgt);
    @(posedge clk); #1;
    check({tag, ".alu_m"}, alu_result_m, res);
    check({tag, ".wdata_m"}, write_data_m, fb);
    check({tag, ".pc4_m"}, pc_plus4_m, pc_plus4_e);
    check({tag, ".ctl_m"}, {23'b0, reg_write_m, mem_write_m, result_src_m, rd_m}, {23'b0, ctl});
    model_m_alu = res;
    $display("txn %s op=%0d a=%h b=%h alu=%h pc_src=%0d tgt=%h", tag, alu_control_e, a, b, res, psrc, tgt);
    @(negedge clk);
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, ".alu_m"}, alu_result_m, 32'b0);
    check({tag, ".wdata_m"}, write_data_m, 32'b0);
    check({tag, ".pc4_m"}, pc_plus4_m, 32'b0);
    check({tag, ".ctl_m"}, {23'b0, reg_write_m, mem_write_m, result_src_m, rd_m}, 32'b0);
  endtask

  task automatic random_txn(input string tag);
    logic [31:0] r1 = $urandom;
    logic [31:0] r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
    set_txn($urandom, $urandom, $urandom, r1, r2, $urandom, 3'($urandom),
            2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0));
    run_txn(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    set_txn(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    reg_write_e = 1'b0; mem_write_e = 1'b0; result_src_e = 2'b0; rd_e = 5'b0;
    #3;
    check_m_zero("reset");
    check("reset.pc_src", {31'b0, pc_src_e}, 32'b0);
    check("reset.target", pc_target_e, 32'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // ALU sweep: src_a = 0xFFFFFFF0 from rd1, src_b = 0x10 from rd2
    set_txn(32'h40, 32'h44, 0, 32'hFFFF_FFF0, 32'h10, 0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("sw_add");
    check("sw_add.spec", alu_result_m, 32'h0);
    set_txn(32'h40, 32'h44, 0, 32'hFFFF_FFF0, 32'h10, 0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("sw_sub");
    check("sw_sub.spec", alu_result_m, 32'hFFFF_FFE0);
    set_txn(32'h40, 32'h44, 0, 32'hFFFF_FFF0, 32'h10, 0, 3'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("sw_slt");
    check("sw_slt.spec", alu_result_m, 32'h1);
    set_txn(32'h40, 32'h44, 0, 32'hFFFF_FFF0, 32'h10, 0, 3'd6, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("sw_sll");
    check("sw_sll.spec", alu_result_m, 32'hFFF0_0000);
    set_txn(32'h40, 32'h44, 0, 32'hFFFF_FFF0, 32'h4, 0, 3'd7, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("sw_sra");
    check("sw_sra.spec", alu_result_m, 32'hFFFF_FFFF);

    // Forwarding: prior M result 0x55, WB result 0x22
    set_txn(0, 4, 0, 32'h50, 32'h5, 0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    run_txn("fwd_pre");
    set_txn(0, 4, 0, 32'h1, 32'h2, 32'h22, 3'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    run_txn("fwd_add");
`ifdef FORWARDING_EN
    check("fwd_add.spec", alu_result_m, 32'h77);
`endif

    // Store data path with immediate operand
    set_txn(0, 4, 32'h8, 32'h1000, 32'h1234, 32'hDEAD_BEEF, 3'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    run_txn("store");
    check("store.addr", alu_result_m, 32'h1008);
`ifdef FORWARDING_EN
    check("store.data", write_data_m, 32'hDEAD_BEEF);
`endif

    // Branch taken / not taken, jump with target wrap
    set_txn(32'h100, 32'h104, 32'hFFFF_FFF0, 32'h77, 32'h77, 0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    run_txn("beq_eq");
    check("beq_eq.pc_src", {31'b0, pc_src_e}, 32'h1);
    check("beq_eq.target", pc_target_e, 32'hF0);
    set_txn(32'h100, 32'h104, 32'hFFFF_FFF0, 32'h77, 32'h78, 0, 3'd1, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    run_txn("beq_ne");
    check("beq_ne.pc_src", {31'b0, pc_src_e}, 32'h0);
    set_txn(32'hFFFF_FFFC, 32'h0, 32'h8, 32'h3, 32'h9, 0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    run_txn("jal_wrap");
    check("jal_wrap.pc_src", {31'b0, pc_src_e}, 32'h1);
    check("jal_wrap.target", pc_target_e, 32'h4);
    check("jal_wrap.pc4_m", pc_plus4_m, 32'h0);

    for (int i = 0; i < 120; i++) random_txn($sformatf("rnd%0d", i));

    // Mid-stream asynchronous reset, then the first edge after release loads
    set_txn(32'h200, 32'h204, 32'h10, 32'hAAAA_0000, 32'h0000_5555, 32'h1, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    reg_write_e = 1'b1; rd_e = 5'd7;
    @(posedge clk); #1;
    check("pre_rst.alu_m", alu_result_m, 32'hAAAA_5555);
    #2 rst_n = 1'b0;
    #1;
    check_m_zero("mid_rst");
    model_m_alu = 32'b0;
    @(negedge clk);
    rst_n = 1'b1;
    random_txn("post_rst");

    for (int i = 0; i < 60; i++) random_txn($sformatf("rndb%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
